breadboard_sweep_ctrl: RTL and testbench

//   Sequencer for the 4-input/10-output Breadboard truth-table datapath.
//   On start, drives w,x,y,z through rows 0..15, waits SETTLE cycles per row,

---
 rtl/breadboard_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_breadboard_sweep_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/breadboard_sweep_ctrl.sv
// Steps {w,x,y,z} through rows 0..15, captures f_in after a settle delay, offers
// each row by valid/ready and folds it into a rotate-XOR signature.
module breadboard_sweep_ctrl #(
  parameter int SETTLE     = 5,
  parameter int MARK_EVERY = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       w_o,
  output logic       x_o,
  output logic       y_o,
  output logic       z_o,
  input  logic [9:0] f_in_i,
  output logic       row_valid_o,
  input  logic       row_ready_i,
  output logic [3:0] row_idx_o,
  output logic [9:0] row_f_o,
  output logic       row_mark_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [9:0] sig_o
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    row_f_q, row_f_d;
  logic [3:0]    row_idx_q, row_idx_d;
  logic          row_mark_q, row_mark_d;
  logic          row_valid_q, row_valid_d;
  logic [9:0]    sig_q, sig_d;
  logic          mark_hit;

  assign mark_hit = ((int'(idx_q) % MARK_EVERY) == (MARK_EVERY - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      row_f_q     <= '0;
      row_idx_q   <= '0;
      row_mark_q  <= 1'b0;
      row_valid_q <= 1'b0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      row_f_q     <= row_f_d;
      row_idx_q   <= row_idx_d;
      row_mark_q  <= row_mark_d;
      row_valid_q <= row_valid_d;
      sig_q       <= sig_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    row_f_d     = row_f_q;
    row_idx_d   = row_idx_q;
    row_mark_d  = row_mark_q;
    row_valid_d = row_valid_q;
    sig_d       = sig_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          cnt_d   = '0;
          sig_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          row_f_d     = f_in_i;
          row_idx_d   = idx_q;
          row_mark_d  = mark_hit;
          sig_d       = {sig_q[8:0], sig_q[9]} ^ f_in_i;
          row_valid_d = 1'b1;
          state_d     = S_PRESENT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PRESENT: begin
        if (row_ready_i) begin
          row_valid_d = 1'b0;
          if (idx_q == 4'hF) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over start and over a pending handshake; the signature is kept.
    if (abort_i) begin
      state_d     = S_IDLE;
      row_valid_d = 1'b0;
      idx_d       = '0;
    end
  end

  assign {w_o, x_o, y_o, z_o} = idx_q;
  assign row_valid_o = row_valid_q;
  assign row_idx_o   = row_idx_q;
  assign row_f_o     = row_f_q;
  assign row_mark_o  = row_mark_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign sig_o       = sig_q;

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Directed bench for breadboard_sweep_ctrl: ordering/timing, signature, stall, abort, reset.
module tb_breadboard_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       w, x, y, z;
  logic [9:0] f_in;
  logic       row_valid;
  logic       row_ready;
  logic [3:0] row_idx;
  logic [9:0] row_f;
  logic       row_mark;
  logic       busy;
  logic       done;
  logic [9:0] sig;

  logic       fmode;
  logic [9:0] fconst;

  int npass = 0;
  int ntot  = 0;

  breadboard_sweep_ctrl #(.SETTLE(5), .MARK_EVERY(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .w_o         (w),
    .x_o         (x),
    .y_o         (y),
    .z_o         (z),
    .f_in_i      (f_in),
    .row_valid_o (row_valid),
    .row_ready_i (row_ready),
    .row_idx_o   (row_idx),
    .row_f_o     (row_f),
    .row_mark_o  (row_mark),
    .busy_o      (busy),
    .done_o      (done),
    .sig_o       (sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Breadboard wiring: f0=w f1=x f2=y f3=z f4=w f5=x f6=y f7=z f8=w f9=x
  function automatic logic [9:0] fmap(input logic [3:0] i);
    logic bw, bx, by, bz;
    {bw, bx, by, bz} = i;
    return {bx, bw, bz, by, bx, bw, bz, by, bx, bw};
  endfunction

  function automatic logic [9:0] rotx(input logic [9:0] s, input logic [9:0] f);
    return {s[8:0], s[9]} ^ f;
  endfunction

  assign f_in = fmode ? fconst : fmap({w, x, y, z});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ntot++;
    assert (obs === exp_v) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!row_valid && n < bound) begin
      tick();
      n++;
    end
    chk("wait_valid", {31'd0, row_valid}, 32'd1);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk("wait_done", {31'd0, done}, 32'd1);
  endtask

  int         rowcnt;
  int         donecnt;
  int         n;
  logic [9:0] sig_exp;
  logic       stable;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; row_ready = 1'b0;
    fmode = 1'b0; fconst = 10'h000;
    #1;
    chk("rst row_valid", {31'd0, row_valid}, 32'd0);
    chk("rst wxyz", {28'd0, w, x, y, z}, 32'd0);
    chk("rst busy/done", {30'd0, busy, done}, 32'd0);
    chk("rst sig", {22'd0, sig}, 32'd0);
    chk("rst row_idx/f/mark", {17'd0, row_idx, row_f, row_mark}, 32'd0);
    #10;
    rst = 1'b0;
    tick();

    // Full sweep with wired f_in, consumer always ready
    row_ready = 1'b1;
    rowcnt = 0; donecnt = 0; sig_exp = 10'h000;
    do_start();
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (row_valid) begin
        chk("row order", {28'd0, row_idx}, rowcnt);
        chk("row timing", c, 5 + 6 * rowcnt);
        chk("row_f", {22'd0, row_f}, {22'd0, fmap(4'(rowcnt))});
        chk("row_mark", {31'd0, row_mark}, {31'd0, (rowcnt % 4) == 3});
        sig_exp = rotx(sig_exp, fmap(4'(rowcnt)));
        if (rowcnt == 5)  chk("row5 f", {22'd0, row_f}, 32'h2AA);
        if (rowcnt == 15) chk("row15 f", {22'd0, row_f}, 32'h3FF);
        rowcnt++;
      end
      if (done) begin
        donecnt++;
        chk("done cycle", c, 96);
        chk("done wxyz", {28'd0, w, x, y, z}, 32'hF);
        chk("done sig", {22'd0, sig}, {22'd0, sig_exp});
      end
    end
    chk("row count", rowcnt, 16);
    chk("done count", donecnt, 1);
    chk("idle after sweep", {31'd0, busy}, 32'd0);

    // Signature with constant f_in
    fmode = 1'b1; fconst = 10'h001;
    do_start();
    wait_done(120);
    chk("sig 001", {22'd0, sig}, 32'h3C0);
    tick();
    chk("sig held", {22'd0, sig}, 32'h3C0);
    chk("idle busy", {31'd0, busy}, 32'd0);

    fconst = 10'h3FF;
    do_start();
    wait_done(120);
    chk("sig 3FF", {22'd0, sig}, 32'h000);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start on DONE->IDLE ignored", {31'd0, busy}, 32'd0);
    tick();
    chk("still idle", {31'd0, busy}, 32'd0);

    // Stall on row 2
    fmode = 1'b0; row_ready = 1'b0;
    do_start();
    for (int r = 0; r < 2; r++) begin
      wait_valid(20);
      row_ready = 1'b1;
      tick();
      row_ready = 1'b0;
    end
    wait_valid(20);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!row_valid || row_idx != 4'd2 || row_f != fmap(4'd2) || {w, x, y, z} != 4'd2)
        stable = 1'b0;
    end
    chk("row2 stall stable", {31'd0, stable}, 32'd1);
    chk("row2 stall idx", {28'd0, row_idx}, 32'd2);
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    chk("row2 handshake clears valid", {31'd0, row_valid}, 32'd0);
    chk("wxyz advanced", {28'd0, w, x, y, z}, 32'd3);
    wait_valid(20);
    chk("row3 after stall", {28'd0, row_idx}, 32'd3);

    // Abort during row 7 settle
    row_ready = 1'b1;
    n = 0;
    while ({w, x, y, z} != 4'd7 && n < 60) begin
      tick();
      n++;
    end
    chk("reached row7", {28'd0, w, x, y, z}, 32'd7);
    sig_exp = 10'h000;
    for (int r = 0; r < 7; r++) sig_exp = rotx(sig_exp, fmap(4'(r)));
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort valid", {31'd0, row_valid}, 32'd0);
    chk("abort wxyz", {28'd0, w, x, y, z}, 32'd0);
    chk("abort partial sig", {22'd0, sig}, {22'd0, sig_exp});
    tick();
    chk("abort no done", {31'd0, done}, 32'd0);

    // Restart, start pulse while busy, reset during row 9 present
    row_ready = 1'b0;
    do_start();
    chk("restart sig", {22'd0, sig}, 32'd0);
    chk("restart wxyz", {28'd0, w, x, y, z}, 32'd0);
    chk("restart busy", {31'd0, busy}, 32'd1);
    for (int r = 0; r < 9; r++) begin
      wait_valid(20);
      chk("restart order", {28'd0, row_idx}, r);
      if (r == 4) start = 1'b1;
      row_ready = 1'b1;
      tick();
      row_ready = 1'b0;
      start = 1'b0;
    end
    wait_valid(20);
    chk("row9 present", {28'd0, row_idx}, 32'd9);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst valid", {31'd0, row_valid}, 32'd0);
    chk("async rst wxyz", {28'd0, w, x, y, z}, 32'd0);
    chk("async rst busy/done", {30'd0, busy, done}, 32'd0);
    chk("async rst sig", {22'd0, sig}, 32'd0);
    chk("async rst row_idx/f/mark", {17'd0, row_idx, row_f, row_mark}, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("post rst idle", {30'd0, busy, done}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
